adc_fault_supervisor: RTL and testbench

//  Sequences fault protection for N_CHANNELS ADC processing channels, sitting between their fault outputs and the modulator.
//  - Arms the channels, aggregates their faults into one registered trip and records which channel tripped first.
//  - Runs a software-acknowledged clear/holdoff/re-arm cycle with a bounded retry count, then locks out.

---
 rtl/adc_supervisor_pkg.sv | 21 ++
 rtl/adc_first_fault_encoder.sv | 12 +
 rtl/adc_fault_supervisor.sv | 203 ++++++++++++++++++++
 tb/tb_adc_fault_supervisor.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_supervisor_pkg.sv
// Shared state encoding for the ADC fault supervisor.
// The numeric codes are what software reads back from the state port.
package adc_supervisor_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMING   = 3'd1,
    ARMED    = 3'd2,
    TRIPPED  = 3'd3,
    CLEARING = 3'd4,
    LOCKOUT  = 3'd5
  } supervisor_state_t;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ARMING   = 3'd1;
  localparam logic [2:0] ST_ARMED    = 3'd2;
  localparam logic [2:0] ST_TRIPPED  = 3'd3;
  localparam logic [2:0] ST_CLEARING = 3'd4;
  localparam logic [2:0] ST_LOCKOUT  = 3'd5;

endpackage

// File: rtl/adc_first_fault_encoder.sv
// Lowest-index one-hot pick of a request vector; combinational.
module adc_first_fault_encoder #(
  parameter int unsigned N_CHANNELS = 4
) (
  input  logic [N_CHANNELS-1:0] request,
  output logic [N_CHANNELS-1:0] first_one_c
);

  // Two's-complement isolate of the least significant set bit.
  assign first_one_c = request & (~request + N_CHANNELS'(1));

endmodule

// File: rtl/adc_fault_supervisor.sv
// Fault protection sequencer for N_CHANNELS ADC channels: arm, trip, clear/holdoff/re-arm, lockout.
// Optional macro FAULT_TIMESTAMP_EN adds a free-running counter captured into fault_timestamp on each trip.
module adc_fault_supervisor
  import adc_supervisor_pkg::*;
#(
  parameter int unsigned N_CHANNELS    = 4,
  parameter int unsigned HOLDOFF_WIDTH = 16,
  parameter int unsigned MAX_RETRIES   = 3
`ifdef FAULT_TIMESTAMP_EN
  ,
  parameter int unsigned TS_WIDTH      = 32
`endif
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               enable,
  input  logic [N_CHANNELS-1:0]              data_in_valid,
  input  logic [N_CHANNELS-1:0]              channel_fault,
  input  logic [N_CHANNELS-1:0]              fault_mask,
  input  logic [HOLDOFF_WIDTH-1:0]           holdoff_cycles,
  input  logic                               clear_request,
  output logic [N_CHANNELS-1:0]              clear_latch,
  output logic [N_CHANNELS-1:0]              channel_disable,
  output logic                               trip,
  output logic [N_CHANNELS-1:0]              first_fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
  output logic                               lockout,
  output logic [2:0]                         state
`ifdef FAULT_TIMESTAMP_EN
  ,
  output logic [TS_WIDTH-1:0]                fault_timestamp
`endif
);

  localparam int unsigned RETRY_WIDTH = $clog2(MAX_RETRIES + 1);

  logic [N_CHANNELS-1:0]    active_c;
  logic [N_CHANNELS-1:0]    active_q;
  logic [N_CHANNELS-1:0]    seen;
  logic [HOLDOFF_WIDTH-1:0] holdoff_cnt;
  logic [N_CHANNELS-1:0]    enc_req_c;
  logic [N_CHANNELS-1:0]    enc_pick_c;

  logic [2:0]               state_nxt;
  logic                     trip_nxt;
  logic                     lockout_nxt;
  logic [N_CHANNELS-1:0]    clear_latch_nxt;
  logic [N_CHANNELS-1:0]    channel_disable_nxt;
  logic [N_CHANNELS-1:0]    first_fault_nxt;
  logic [RETRY_WIDTH-1:0]   retry_count_nxt;
  logic [N_CHANNELS-1:0]    seen_nxt;
  logic [HOLDOFF_WIDTH-1:0] holdoff_cnt_nxt;

  assign active_c = channel_fault & ~fault_mask;

  // ARMED trips on the previous-cycle sample; clearing expiry recaptures from the live vector.
  assign enc_req_c = (state == ST_ARMED) ? active_q : active_c;

  adc_first_fault_encoder #(
    .N_CHANNELS (N_CHANNELS)
  ) u_first_fault_encoder (
    .request     (enc_req_c),
    .first_one_c (enc_pick_c)
  );

  // Next-state and next-output decode.
  always_comb begin
    state_nxt           = state;
    trip_nxt            = trip;
    lockout_nxt         = lockout;
    clear_latch_nxt     = '0;
    channel_disable_nxt = channel_disable;
    first_fault_nxt     = first_fault;
    retry_count_nxt     = retry_count;
    seen_nxt            = seen;
    holdoff_cnt_nxt     = holdoff_cnt;

    if (!enable) begin
      state_nxt           = ST_IDLE;
      trip_nxt            = 1'b0;
      lockout_nxt         = 1'b0;
      channel_disable_nxt = '1;
      first_fault_nxt     = '0;
      retry_count_nxt     = '0;
      seen_nxt            = '0;
      holdoff_cnt_nxt     = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt           = ST_ARMING;
          channel_disable_nxt = '0;
          seen_nxt            = '0;
        end
        ST_ARMING: begin
          channel_disable_nxt = '0;
          seen_nxt            = seen | data_in_valid;
          if (((seen | fault_mask) == '1) && (active_c == '0)) begin
            state_nxt = ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (active_q != '0) begin
            state_nxt           = ST_TRIPPED;
            trip_nxt            = 1'b1;
            first_fault_nxt     = enc_pick_c;
            channel_disable_nxt = '1;
          end
        end
        ST_TRIPPED: begin
          channel_disable_nxt = '1;
          if (clear_request) begin
            if (retry_count == RETRY_WIDTH'(MAX_RETRIES)) begin
              state_nxt   = ST_LOCKOUT;
              lockout_nxt = 1'b1;
            end else begin
              state_nxt       = ST_CLEARING;
              clear_latch_nxt = '1;
              holdoff_cnt_nxt = (holdoff_cycles == '0) ? HOLDOFF_WIDTH'(1) : holdoff_cycles;
            end
          end
        end
        ST_CLEARING: begin
          if (holdoff_cnt <= HOLDOFF_WIDTH'(1)) begin
            if (retry_count != RETRY_WIDTH'(MAX_RETRIES)) begin
              retry_count_nxt = retry_count + RETRY_WIDTH'(1);
            end
            seen_nxt = '0;
            if (active_c == '0) begin
              state_nxt           = ST_ARMING;
              trip_nxt            = 1'b0;
              first_fault_nxt     = '0;
              channel_disable_nxt = '0;
            end else begin
              state_nxt       = ST_TRIPPED;
              trip_nxt        = 1'b1;
              first_fault_nxt = enc_pick_c;
            end
          end else begin
            holdoff_cnt_nxt = holdoff_cnt - HOLDOFF_WIDTH'(1);
          end
        end
        ST_LOCKOUT: begin
          trip_nxt            = 1'b1;
          lockout_nxt         = 1'b1;
          channel_disable_nxt = '1;
        end
        default: begin
          state_nxt           = ST_IDLE;
          trip_nxt            = 1'b0;
          lockout_nxt         = 1'b0;
          channel_disable_nxt = '1;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      trip            <= 1'b0;
      lockout         <= 1'b0;
      clear_latch     <= '0;
      channel_disable <= '1;
      first_fault     <= '0;
      retry_count     <= '0;
      seen            <= '0;
      holdoff_cnt     <= '0;
      active_q        <= '0;
    end else begin
      state           <= state_nxt;
      trip            <= trip_nxt;
      lockout         <= lockout_nxt;
      clear_latch     <= clear_latch_nxt;
      channel_disable <= channel_disable_nxt;
      first_fault     <= first_fault_nxt;
      retry_count     <= retry_count_nxt;
      seen            <= seen_nxt;
      holdoff_cnt     <= holdoff_cnt_nxt;
      active_q        <= active_c;
    end
  end

`ifdef FAULT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_count;
  logic                ts_capture_c;

  // Every entry into TRIPPED (from ARMED or CLEARING) stamps the free-running count.
  assign ts_capture_c = (state_nxt == ST_TRIPPED) && (state != ST_TRIPPED);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_count        <= '0;
      fault_timestamp <= '0;
    end else begin
      ts_count <= ts_count + TS_WIDTH'(1);
      if (ts_capture_c) begin
        fault_timestamp <= ts_count;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adc_fault_supervisor.sv
// Randomized + directed bench for adc_fault_supervisor against a cycle-level behavioural model.
// Honours FAULT_TIMESTAMP_EN when the design is built with it.
module tb_adc_fault_supervisor;

  localparam int unsigned MAX_R = 3;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [3:0]  data_in_valid;
  logic [3:0]  channel_fault;
  logic [3:0]  fault_mask;
  logic [15:0] holdoff_cycles;
  logic        clear_request;
  logic [3:0]  clear_latch;
  logic [3:0]  channel_disable;
  logic        trip;
  logic [3:0]  first_fault;
  logic [1:0]  retry_count;
  logic        lockout;
  logic [2:0]  state;
`ifdef FAULT_TIMESTAMP_EN
  logic [31:0] fault_timestamp;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  adc_fault_supervisor dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .data_in_valid   (data_in_valid),
    .channel_fault   (channel_fault),
    .fault_mask      (fault_mask),
    .holdoff_cycles  (holdoff_cycles),
    .clear_request   (clear_request),
    .clear_latch     (clear_latch),
    .channel_disable (channel_disable),
    .trip            (trip),
    .first_fault     (first_fault),
    .retry_count     (retry_count),
    .lockout         (lockout),
    .state           (state)
`ifdef FAULT_TIMESTAMP_EN
    ,
    .fault_timestamp (fault_timestamp)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: phase number, holdoff as an absolute deadline edge, timestamps as edge index.
  int          m_state;
  logic        m_trip;
  logic        m_lock;
  logic [3:0]  m_clr;
  logic [3:0]  m_dis;
  logic [3:0]  m_ff;
  int          m_retry;
  logic [3:0]  m_seen;
  logic [3:0]  m_prev_act;
  int          m_edge;
  int          m_deadline;
  logic [31:0] m_ts;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) begin
      if (v[i]) return 4'(1 << i);
    end
    return 4'h0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_trip = 1'b0; m_lock = 1'b0; m_clr = 4'h0; m_dis = 4'hF;
    m_ff = 4'h0; m_retry = 0; m_seen = 4'h0; m_prev_act = 4'h0;
    m_edge = 0; m_deadline = 0; m_ts = 32'h0;
  endtask

  task automatic model_step(input logic en, input logic [3:0] valid, input logic [3:0] fault,
                            input logic [3:0] mask, input logic [15:0] hold, input logic clr);
    logic [3:0] act;
    bit ready;
    act   = fault & ~mask;
    m_clr = 4'h0;
    if (!en) begin
      m_state = 0; m_trip = 1'b0; m_lock = 1'b0; m_ff = 4'h0; m_retry = 0;
      m_seen = 4'h0; m_dis = 4'hF;
    end else begin
      case (m_state)
        0: begin m_state = 1; m_dis = 4'h0; m_seen = 4'h0; end
        1: begin
          ready = 1'b1;
          for (int i = 0; i < 4; i++) if (!m_seen[i] && !mask[i]) ready = 1'b0;
          m_seen = m_seen | valid;
          if (ready && act == 4'h0) m_state = 2;
        end
        2: if (m_prev_act != 4'h0) begin
          m_state = 3; m_trip = 1'b1; m_ff = lowest(m_prev_act); m_dis = 4'hF;
          m_ts = 32'(m_edge);
        end
        3: if (clr) begin
          if (m_retry == MAX_R) begin
            m_state = 5; m_lock = 1'b1;
          end else begin
            m_state = 4; m_clr = 4'hF;
            m_deadline = m_edge + ((hold == 16'd0) ? 1 : int'(hold));
          end
        end
        4: if (m_edge == m_deadline) begin
          if (m_retry < MAX_R) m_retry++;
          m_seen = 4'h0;
          if (act == 4'h0) begin
            m_state = 1; m_trip = 1'b0; m_ff = 4'h0; m_dis = 4'h0;
          end else begin
            m_state = 3; m_ff = lowest(act); m_ts = 32'(m_edge);
          end
        end
        default: ;
      endcase
    end
    m_prev_act = act;
    m_edge++;
  endtask

  task automatic compare_all();
    check("state",           32'(state),           32'(m_state));
    check("trip",            32'(trip),            32'(m_trip));
    check("lockout",         32'(lockout),         32'(m_lock));
    check("clear_latch",     32'(clear_latch),     32'(m_clr));
    check("channel_disable", 32'(channel_disable), 32'(m_dis));
    check("first_fault",     32'(first_fault),     32'(m_ff));
    check("retry_count",     32'(retry_count),     32'(m_retry));
`ifdef FAULT_TIMESTAMP_EN
    check("fault_timestamp", fault_timestamp,      m_ts);
`endif
  endtask

  // One clock: drive inputs now, advance the model, compare just after the edge.
  task automatic step(input logic en, input logic [3:0] valid, input logic [3:0] fault,
                      input logic [3:0] mask, input logic [15:0] hold, input logic clr);
    enable = en; data_in_valid = valid; channel_fault = fault;
    fault_mask = mask; holdoff_cycles = hold; clear_request = clr;
    model_step(en, valid, fault, mask, hold, clr);
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},   32'(state),           32'd0);
    check({tag, "_trip"},    32'(trip),            32'd0);
    check({tag, "_lockout"}, 32'(lockout),         32'd0);
    check({tag, "_clr"},     32'(clear_latch),     32'd0);
    check({tag, "_dis"},     32'(channel_disable), 32'hF);
    check({tag, "_ff"},      32'(first_fault),     32'd0);
    check({tag, "_retry"},   32'(retry_count),     32'd0);
`ifdef FAULT_TIMESTAMP_EN
    check({tag, "_ts"},      fault_timestamp,      32'd0);
`endif
  endtask

  initial begin
    logic [3:0] fault_r;
    logic [3:0] mask_r;
    reset = 1'b1; enable = 1'b0; data_in_valid = 4'h0; channel_fault = 4'h0;
    fault_mask = 4'h0; holdoff_cycles = 16'd0; clear_request = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_reset_values("reset");
    @(negedge clock);
    reset = 1'b0;

    // Arming with valid strobes on each channel in turn
    step(1, 4'h0, 4'h0, 4'h0, 16'd5, 0);
    for (int i = 0; i < 4; i++) step(1, 4'(1 << i), 4'h0, 4'h0, 16'd5, 0);
    check("t1_still_arming", 32'(state), 32'd1);
    step(1, 4'h0, 4'h0, 4'h0, 16'd5, 0);
    check("t1_armed", 32'(state), 32'd2);
    check("t1_enabled", 32'(channel_disable), 32'h0);

    // Simultaneous faults: one-cycle latency, lowest index wins
    step(1, 4'h0, 4'b0110, 4'h0, 16'd5, 0);
    check("t2_no_trip_yet", 32'(trip), 32'd0);
    step(1, 4'h0, 4'h0, 4'h0, 16'd5, 0);
    check("t2_trip", 32'(trip), 32'd1);
    check("t2_first_fault", 32'(first_fault), 32'b0010);
    check("t2_state", 32'(state), 32'd3);

    // Clear with holdoff 5 and no fault
    step(1, 4'h0, 4'h0, 4'h0, 16'd5, 1);
    check("t3_clear_pulse", 32'(clear_latch), 32'hF);
    step(1, 4'h0, 4'h0, 4'h0, 16'd5, 1);
    check("t3_pulse_one_cycle", 32'(clear_latch), 32'h0);
    repeat (3) step(1, 4'h0, 4'h0, 4'h0, 16'd5, 0);
    check("t3_still_clearing", 32'(state), 32'd4);
    step(1, 4'h0, 4'h0, 4'h0, 16'd5, 0);
    check("t3_rearming", 32'(state), 32'd1);
    check("t3_retry", 32'(retry_count), 32'd1);

    // Persistent fault: retries exhaust, then lockout
    step(1, 4'hF, 4'h0, 4'h0, 16'd2, 0);
    step(1, 4'h0, 4'h0, 4'h0, 16'd2, 0);
    step(1, 4'h0, 4'hF, 4'h0, 16'd2, 0);
    step(1, 4'h0, 4'hF, 4'h0, 16'd2, 0);
    check("t4_tripped", 32'(state), 32'd3);
    for (int k = 0; k < 2; k++) begin
      step(1, 4'h0, 4'hF, 4'h0, 16'd2, 1);
      step(1, 4'h0, 4'hF, 4'h0, 16'd2, 0);
      step(1, 4'h0, 4'hF, 4'h0, 16'd2, 0);
      check("t4_retrip", 32'(state), 32'd3);
      check("t4_retry", 32'(retry_count), 32'(k + 2));
    end
    step(1, 4'h0, 4'hF, 4'h0, 16'd2, 1);
    check("t4_lockout", 32'(lockout), 32'd1);
    check("t4_lock_state", 32'(state), 32'd5);
    step(1, 4'h0, 4'h0, 4'h0, 16'd2, 1);
    check("t4_lock_sticky", 32'(state), 32'd5);
    step(0, 4'h0, 4'h0, 4'h0, 16'd2, 0);
    check("t4_idle", 32'(state), 32'd0);
    check("t4_retry_clr", 32'(retry_count), 32'd0);

    // Masked faults never trip; fully masked arming takes one cycle
    step(1, 4'h0, 4'h0, 4'b1000, 16'd1, 0);
    step(1, 4'b0111, 4'h0, 4'b1000, 16'd1, 0);
    step(1, 4'h0, 4'h0, 4'b1000, 16'd1, 0);
    check("t5_armed_masked", 32'(state), 32'd2);
    repeat (3) step(1, 4'h0, 4'b1000, 4'b1000, 16'd1, 0);
    check("t5_no_trip", 32'(trip), 32'd0);
    step(0, 4'h0, 4'h0, 4'hF, 16'd1, 0);
    step(1, 4'h0, 4'h0, 4'hF, 16'd1, 0);
    step(1, 4'h0, 4'h0, 4'hF, 16'd1, 0);
    check("t5_all_masked", 32'(state), 32'd2);

    // Async reset right after a clear, while the clear pulse is out
    step(1, 4'h0, 4'b0010, 4'h0, 16'd10, 0);
    step(1, 4'h0, 4'h0, 4'h0, 16'd10, 0);
    check("t6_first_fault", 32'(first_fault), 32'b0010);
    step(1, 4'h0, 4'h0, 4'h0, 16'd10, 1);
    check("t6_clearing", 32'(state), 32'd4);
    #2;
    reset = 1'b1;
    #1;
    check_reset_values("t6_async");
    model_reset();
    @(negedge clock);
    reset = 1'b0;

    // Randomized traffic
    fault_r = 4'h0;
    mask_r  = 4'h0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) == 0)
        mask_r = ($urandom_range(0, 3) == 0) ? 4'hF : (4'($urandom) & 4'($urandom));
      if ($urandom_range(0, 7) == 0)      fault_r = 4'($urandom);
      else if ($urandom_range(0, 1) == 0) fault_r = 4'h0;
      step($urandom_range(0, 199) != 0, 4'($urandom), fault_r, mask_r,
           16'($urandom_range(0, 6)), $urandom_range(0, 5) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
